// File: rtl/front_panel_io.sv
// Front-panel board I/O: multiplexed seven-segment scanner, per-button debouncer with press pulses,
// and switch synchroniser. Optional leading-zero blanking is enabled by defining FP_BLANK_ZERO_EN.
module front_panel_io #(
  parameter int DIGITS          = 8,
  parameter int SCAN_DIV        = 100000,
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   display_value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     digit_enable,
  input  logic [NUM_BTNS-1:0]   btn_raw,
  input  logic [SW_WIDTH-1:0]   sw_raw,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_BTNS-1:0]   btn_level,
  output logic [NUM_BTNS-1:0]   btn_press,
  output logic [SW_WIDTH-1:0]   sw_sync
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
    $error("front_panel_io: DIGITS must be within 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan
    $error("front_panel_io: SCAN_DIV must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("front_panel_io: DEBOUNCE_CYCLES must be >= 2");
  end
  if (NUM_BTNS < 1) begin : g_bad_btns
    $error("front_panel_io: NUM_BTNS must be >= 1");
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PRE_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [3:0]          w_nib;
  logic                w_blank_lz;
  logic                w_show;
  logic [DIGITS-1:0]   w_an;

  logic [NUM_BTNS-1:0] r_btn_m;
  logic [NUM_BTNS-1:0] r_btn_s;
  logic [NUM_BTNS-1:0] r_btn_level;
  logic [NUM_BTNS-1:0] r_btn_press;
  logic [DEB_W-1:0]    r_btn_cnt [NUM_BTNS];

  logic [SW_WIDTH-1:0] r_sw_m;
  logic [SW_WIDTH-1:0] r_sw_s;

`ifdef FP_BLANK_ZERO_EN
  logic [DIGITS-1:0]   w_upper_zero;

  // w_upper_zero[i]: every nibble from digit i up to the leftmost digit is zero
  always_comb begin
    w_upper_zero = '0;
    w_upper_zero[DIGITS-1] = (display_value[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_upper_zero[i] = w_upper_zero[i+1] && (display_value[4*i +: 4] == 4'h0);
    end
  end

  assign w_blank_lz = (r_idx != IDX_W'(0)) && w_upper_zero[r_idx];
`else
  assign w_blank_lz = 1'b0;
`endif

  assign w_nib  = display_value[{r_idx, 2'b00} +: 4];
  assign w_show = digit_enable[r_idx] && !w_blank_lz;
  assign w_an   = ~(DIGITS'(1) << r_idx);

  // Prescaler, digit index and registered anode/segment drive
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      if (r_presc == PRE_LAST) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? IDX_W'(0) : r_idx + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
      if (w_show) begin
        r_an  <= w_an;
        r_seg <= hex_to_seg(w_nib);
        r_dp  <= ~dp_mask[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  // Button synchronisers and per-bit debounce: level follows sync only after a full stable run
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_m     <= '0;
      r_btn_s     <= '0;
      r_btn_level <= '0;
      r_btn_press <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        r_btn_cnt[i] <= '0;
      end
    end else begin
      r_btn_m <= btn_raw;
      r_btn_s <= r_btn_m;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (r_btn_s[i] != r_btn_level[i]) begin
          if (r_btn_cnt[i] == DEB_LAST) begin
            r_btn_level[i] <= r_btn_s[i];
            r_btn_press[i] <= r_btn_s[i];
            r_btn_cnt[i]   <= '0;
          end else begin
            r_btn_press[i] <= 1'b0;
            r_btn_cnt[i]   <= r_btn_cnt[i] + DEB_W'(1);
          end
        end else begin
          r_btn_press[i] <= 1'b0;
          r_btn_cnt[i]   <= '0;
        end
      end
    end
  end

  // Two-flop switch synchroniser, no filtering
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sw_m <= '0;
      r_sw_s <= '0;
    end else begin
      r_sw_m <= sw_raw;
      r_sw_s <= r_sw_m;
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign btn_level = r_btn_level;
  assign btn_press = r_btn_press;
  assign sw_sync   = r_sw_s;

endmodule

// File: tb/tb_front_panel_io.sv
// Randomised bench for front_panel_io with a cycle-level reference model of scan, debounce and sync.
module tb_front_panel_io;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int NB       = 2;
  localparam int DEB      = 8;
  localparam int SW_W     = 13;

  logic            clock = 1'b0;
  logic            reset;
  logic [15:0]     display_value;
  logic [3:0]      dp_mask;
  logic [3:0]      digit_enable;
  logic [NB-1:0]   btn_raw;
  logic [SW_W-1:0] sw_raw;
  logic [3:0]      an;
  logic [6:0]      seg;
  logic            dp;
  logic [NB-1:0]   btn_level;
  logic [NB-1:0]   btn_press;
  logic [SW_W-1:0] sw_sync;

  int tests_run = 0;
  int tests_failed = 0;

  int              md_n;
  logic [NB-1:0]   mb_m, mb_s, mb_lvl, mb_press;
  int              mb_run [NB];
  logic [SW_W-1:0] msw_m, msw_s;
  logic [3:0]      e_an;
  logic [6:0]      e_seg;
  logic            e_dp;
  int              e_digit;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  front_panel_io #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .NUM_BTNS(NB),
    .DEBOUNCE_CYCLES(DEB), .SW_WIDTH(SW_W)
  ) dut (
    .clock(clock), .reset(reset), .display_value(display_value), .dp_mask(dp_mask),
    .digit_enable(digit_enable), .btn_raw(btn_raw), .sw_raw(sw_raw), .an(an), .seg(seg),
    .dp(dp), .btn_level(btn_level), .btn_press(btn_press), .sw_sync(sw_sync)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    md_n = 0;
    mb_m = '0; mb_s = '0; mb_lvl = '0; mb_press = '0;
    for (int i = 0; i < NB; i++) mb_run[i] = 0;
    msw_m = '0; msw_s = '0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_digit = 0;
  endtask

  // One clock edge: advance the reference model from the inputs held across the edge
  task automatic tick();
    logic blank;
    @(posedge clock);
    md_n++;
    e_digit = ((md_n - 1) / SCAN_DIV) % DIGITS;
    blank = !digit_enable[e_digit];
`ifdef FP_BLANK_ZERO_EN
    if (e_digit > 0 && (display_value >> (4 * e_digit)) == 16'h0) blank = 1'b1;
`endif
    if (blank) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = 4'hF;
      e_an[e_digit] = 1'b0;
      e_seg = hex_tab[display_value[4*e_digit +: 4]];
      e_dp = !dp_mask[e_digit];
    end
    for (int i = 0; i < NB; i++) begin
      mb_press[i] = 1'b0;
      if (mb_s[i] != mb_lvl[i]) begin
        mb_run[i]++;
        if (mb_run[i] == DEB) begin
          mb_lvl[i] = mb_s[i];
          mb_press[i] = mb_s[i];
          mb_run[i] = 0;
        end
      end else begin
        mb_run[i] = 0;
      end
    end
    mb_s = mb_m; mb_m = btn_raw;
    msw_s = msw_m; msw_m = sw_raw;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    display_value = 16'($urandom); dp_mask = 4'($urandom); digit_enable = 4'hF;
    btn_raw = '0; sw_raw = 13'($urandom);
    @(negedge clock); @(negedge clock);
    tests_run++; if (an !== 4'hF) begin tests_failed++; $display("FAIL reset_an: got %b expected 1111", an); end
    tests_run++; if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    tests_run++; if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b expected 1", dp); end
    tests_run++; if (btn_level !== 2'b00 || btn_press !== 2'b00) begin
      tests_failed++; $display("FAIL reset_btn: got level %b press %b expected 00 00", btn_level, btn_press); end
    tests_run++; if (sw_sync !== 13'h0) begin tests_failed++; $display("FAIL reset_sw: got %h expected 0", sw_sync); end
    model_reset();
    display_value = 16'h1234; dp_mask = 4'h0; digit_enable = 4'hF;
    reset = 1'b0;
  endtask

  task automatic test_scan_directed();
    logic [3:0] want;
    for (int k = 0; k < 16; k++) begin
      tick();
      want = ~(4'b0001 << (k / 4));
      tests_run++; if (an !== want) begin
        tests_failed++; $display("FAIL scan_seq clk %0d: got an %b expected %b", k + 1, an, want); end
      if (k == 0) begin
        tests_run++; if (seg !== 7'b0011001) begin
          tests_failed++; $display("FAIL scan_digit0_seg: got %b expected 0011001", seg); end
      end
    end
  endtask

  task automatic test_scan_random();
    for (int k = 0; k < 200; k++) begin
      display_value = 16'($urandom);
      dp_mask = 4'($urandom);
      digit_enable = 4'($urandom) | 4'($urandom);
      tick();
      tests_run++; if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        tests_failed++;
        $display("FAIL scan_random: got an %b seg %h dp %b expected an %b seg %h dp %b", an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_dp_enable();
    display_value = 16'h9876; dp_mask = 4'b0100; digit_enable = 4'b0111;
    for (int k = 0; k < 16; k++) begin
      tick();
      tests_run++; if (an !== e_an || seg !== e_seg) begin
        tests_failed++; $display("FAIL dp_en_model: got an %b seg %h expected an %b seg %h", an, seg, e_an, e_seg); end
      tests_run++; if (dp !== ((e_digit == 2) ? 1'b0 : 1'b1)) begin
        tests_failed++; $display("FAIL dp_only_digit2: got dp %b on digit %0d", dp, e_digit); end
      if (e_digit == 3) begin
        tests_run++; if (an !== 4'hF || seg !== 7'h7F) begin
          tests_failed++; $display("FAIL disabled_digit3: got an %b seg %h expected 1111 7f", an, seg); end
      end
    end
  endtask

  task automatic test_buttons_directed();
    int rise_at = -1;
    int presses = 0;
    btn_raw = '0;
    for (int k = 0; k < 12; k++) tick();
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_level[0] === 1'b1 && rise_at < 0) rise_at = k;
      if (btn_press[0] === 1'b1) presses++;
      tests_run++; if (btn_level !== mb_lvl || btn_press !== mb_press) begin
        tests_failed++; $display("FAIL btn0_model clk %0d: got %b/%b expected %b/%b", k, btn_level, btn_press, mb_lvl, mb_press); end
    end
    tests_run++; if (rise_at != 10) begin tests_failed++; $display("FAIL btn0_latency: got %0d expected 10", rise_at); end
    tests_run++; if (presses != 1) begin tests_failed++; $display("FAIL btn0_press_count: got %0d expected 1", presses); end
    btn_raw[0] = 1'b0;
    presses = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (btn_press[0] === 1'b1) presses++;
    end
    tests_run++; if (presses != 0 || btn_level[0] !== 1'b0) begin
      tests_failed++; $display("FAIL btn0_release: got presses %0d level %b expected 0 0", presses, btn_level[0]); end
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 5) btn_raw[1] = 1'b0;
      tick();
      tests_run++; if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
        tests_failed++; $display("FAIL btn1_glitch clk %0d: got level %b press %b expected 0 0", k, btn_level[1], btn_press[1]); end
    end
  endtask

  task automatic test_buttons_random();
    int hold [NB];
    for (int i = 0; i < NB; i++) hold[i] = 1;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = int'($urandom_range(1, 16));
        end
      end
      tick();
      tests_run++; if (btn_level !== mb_lvl || btn_press !== mb_press) begin
        tests_failed++; $display("FAIL btn_random clk %0d: got %b/%b expected %b/%b", k, btn_level, btn_press, mb_lvl, mb_press); end
    end
    btn_raw = '0;
  endtask

  task automatic test_switches();
    for (int k = 0; k < 40; k++) begin
      sw_raw = 13'($urandom);
      tick();
      tests_run++; if (sw_sync !== msw_s) begin
        tests_failed++; $display("FAIL sw_sync clk %0d: got %h expected %h", k, sw_sync, msw_s); end
    end
  endtask

  task automatic test_reset_midscan();
    int guard = 0;
    display_value = 16'h1234; dp_mask = 4'h0; digit_enable = 4'hF;
    tick();
    while (e_digit != 2 && guard < 40) begin
      tick();
      guard++;
    end
    tests_run++; if (an !== 4'b1011) begin
      tests_failed++; $display("FAIL midscan_reach: got an %b expected 1011 (guard %0d)", an, guard); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      tests_failed++; $display("FAIL midscan_async_blank: got an %b seg %h dp %b expected 1111 7f 1", an, seg, dp); end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    tick();
    tests_run++; if (an !== 4'b1110 || seg !== 7'b0011001) begin
      tests_failed++; $display("FAIL midscan_restart: got an %b seg %b expected 1110 0011001", an, seg); end
  endtask

  task automatic test_blank_zero();
    logic [3:0] want_an;
    logic [6:0] want_seg;
    display_value = 16'h0050; dp_mask = 4'h0; digit_enable = 4'hF;
    for (int k = 0; k < 16; k++) begin
      tick();
      want_an = ~(4'b0001 << e_digit);
      want_seg = (e_digit == 1) ? 7'b0010010 : 7'b1000000;
`ifdef FP_BLANK_ZERO_EN
      if (e_digit >= 2) begin want_an = 4'hF; want_seg = 7'h7F; end
`endif
      tests_run++; if (an !== want_an || seg !== want_seg) begin
        tests_failed++; $display("FAIL blank_zero digit %0d: got an %b seg %b expected %b %b", e_digit, an, seg, want_an, want_seg); end
      tests_run++; if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        tests_failed++; $display("FAIL blank_zero_model: got an %b seg %h dp %b expected %b %h %b", an, seg, dp, e_an, e_seg, e_dp); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_directed();
    test_scan_random();
    test_dp_enable();
    test_buttons_directed();
    test_buttons_random();
    test_switches();
    test_reset_midscan();
    test_blank_zero();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
